// File: rtl/pico_reset_seq.sv
// pico_reset_seq: tile reset sequencer with synchronised release, minimum hold and staggered per-domain release
module pico_reset_seq #(
  parameter int SYNC_STAGES = 4,
  parameter int NUM_OUT     = 3,
  parameter int MIN_ASSERT  = 16,
  parameter int STAGGER     = 8
) (
  input  logic               gclk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] grst_l_o,
  output logic               rst_done,
  output logic               seq_busy
);
  localparam int CNT_W = $clog2((MIN_ASSERT > STAGGER ? MIN_ASSERT : STAGGER) + 1);
  localparam int IDX_W = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  typedef enum logic [1:0] {SYNC, HOLD, REL, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_OUT-1:0] grst_d;
  logic done_d, busy_d, sync_go, hold_last, rel_last, idx_last;
  // Look ahead one stage so domain 0 can release on the same edge the last stage sets
  assign sync_go   = |sync_q[SYNC_STAGES-1 -: 2];
  assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  assign hold_last = int'(cnt_q) + 1 >= MIN_ASSERT;
  assign rel_last  = int'(cnt_q) >= STAGGER - 1;
  assign idx_last  = int'(idx_q) >= NUM_OUT - 1;
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SYNC;
      sync_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      grst_l_o <= '0;
      rst_done <= 1'b0;
      seq_busy <= 1'b1;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      grst_l_o <= grst_d;
      rst_done <= done_d;
      seq_busy <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    idx_d   = idx_q;
    case (state_q)
      SYNC: begin
        cnt_d = '0;
        idx_d = '0;
        if (sync_go) state_d = MIN_ASSERT == 0 ? REL : HOLD;
      end
      HOLD: if (hold_last) begin
        state_d = REL;
        cnt_d   = '0;
        idx_d   = '0;
      end
      REL: if (idx_last) state_d = DONE;
        else if (rel_last) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
        end
      default: begin
        cnt_d = '0;
        if (sw_rst_req) state_d = HOLD;
      end
    endcase
  end
  // Outputs are registered from the next state so every release bit is a flop
  always_comb begin
    grst_d = '0;
    for (int i = 0; i < NUM_OUT; i++)
      grst_d[i] = state_d == DONE || (state_d == REL && i <= int'(idx_d));
    done_d = state_d == DONE;
    busy_d = state_d != DONE;
  end
endmodule

// File: tb/tb_pico_reset_seq.sv
// tb_pico_reset_seq: directed vector bench for default, legacy and zero-hold sequencer configurations
module tb_pico_reset_seq;
  logic gclk = 1'b0, rst_n = 1'b0, sw_rst_req = 1'b0;
  logic [2:0] g0, g2;
  logic [0:0] g1;
  logic d0, b0, d1, b1, d2, b2;
  int checks = 0, errors = 0, ecount = 0;

  pico_reset_seq u0 (.gclk(gclk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
                     .grst_l_o(g0), .rst_done(d0), .seq_busy(b0));
  pico_reset_seq #(.SYNC_STAGES(4), .NUM_OUT(1), .MIN_ASSERT(0), .STAGGER(1)) u1 (
    .gclk(gclk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .grst_l_o(g1), .rst_done(d1), .seq_busy(b1));
  pico_reset_seq #(.SYNC_STAGES(4), .NUM_OUT(3), .MIN_ASSERT(0), .STAGGER(8)) u2 (
    .gclk(gclk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .grst_l_o(g2), .rst_done(d2), .seq_busy(b2));

  always #5 gclk = ~gclk;

  typedef struct {int e; logic req; logic [4:0] exp;} vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
    ecount++;
  endtask

  task automatic run_to(input int e);
    while (ecount < e) step();
  endtask

  task automatic cold_release();
    rst_n = 1'b0;
    @(posedge gclk);
    #2;
    rst_n = 1'b1;
    ecount = 0;
  endtask

  initial begin
    // {grst_l_o, rst_done, seq_busy} after the listed edge of the default instance
    tbl = '{
      '{1,  1'b0, 5'b000_0_1}, '{19, 1'b0, 5'b000_0_1}, '{20, 1'b0, 5'b001_0_1},
      '{22, 1'b1, 5'b001_0_1}, '{27, 1'b0, 5'b001_0_1}, '{28, 1'b0, 5'b011_0_1},
      '{35, 1'b0, 5'b011_0_1}, '{36, 1'b0, 5'b111_0_1}, '{37, 1'b0, 5'b111_1_0},
      '{49, 1'b0, 5'b111_1_0}, '{50, 1'b1, 5'b000_0_1}, '{51, 1'b0, 5'b000_0_1},
      '{65, 1'b0, 5'b000_0_1}, '{66, 1'b0, 5'b001_0_1}, '{74, 1'b0, 5'b011_0_1},
      '{81, 1'b0, 5'b011_0_1}, '{82, 1'b0, 5'b111_0_1}, '{83, 1'b0, 5'b111_1_0}
    };
    #12;
    chk("reset_state", {g0, d0, b0}, 5'b000_0_1);
    chk("reset_state_legacy", {g1, d1, b1}, 3'b0_0_1);
    cold_release();
    for (int k = 0; k < 18; k++) begin
      run_to(tbl[k].e - 1);
      sw_rst_req = tbl[k].req;
      step();
      sw_rst_req = 1'b0;
      chk($sformatf("tbl_edge%0d", tbl[k].e), {g0, d0, b0}, tbl[k].exp);
    end
    cold_release();
    run_to(3);
    chk("legacy_e3", {g1, d1, b1}, 3'b0_0_1);
    chk("zh_e3", g2, 3'b000);
    step();
    chk("legacy_e4", {g1, d1, b1}, 3'b1_0_1);
    chk("zh_e4", g2, 3'b001);
    step();
    chk("legacy_e5", {g1, d1, b1}, 3'b1_1_0);
    run_to(11);
    chk("zh_e11", g2, 3'b001);
    step();
    chk("zh_e12", g2, 3'b011);
    run_to(20);
    chk("zh_e20", {g2, d2}, 4'b111_0);
    step();
    chk("zh_e21", {g2, d2, b2}, 5'b111_1_0);
    run_to(25);
    chk("mid_e25", g0, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clr", {g0, d0, b0}, 5'b000_0_1);
    chk("async_clr_zh", {g2, d2, b2}, 5'b000_0_1);
    @(posedge gclk);
    #2 rst_n = 1'b1;
    ecount = 0;
    run_to(10);
    chk("pre_glitch_legacy", g1, 1'b1);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    ecount = 0;
    #1;
    chk("glitch_clr", {g1, d1, b1, g2}, 6'b0_0_1_000);
    run_to(3);
    chk("glitch_e3", g1, 1'b0);
    step();
    chk("glitch_e4", g1, 1'b1);
    run_to(19);
    chk("recold_e19", g0, 3'b000);
    step();
    chk("recold_e20", g0, 3'b001);
    run_to(36);
    chk("recold_e36", {g0, d0}, 4'b111_0);
    step();
    chk("recold_e37", {g0, d0, b0}, 5'b111_1_0);
    run_to(49);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("zh_warm_e50", {g2, d2, b2}, 5'b000_0_1);
    chk("legacy_warm_e50", {g1, d1, b1}, 3'b0_0_1);
    step();
    chk("zh_warm_e51", g2, 3'b001);
    chk("legacy_warm_e51", {g1, d1}, 2'b1_0);
    step();
    chk("legacy_warm_e52", {g1, d1, b1}, 3'b1_1_0);
    run_to(59);
    chk("zh_warm_e59", g2, 3'b011);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
